alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
Upstream operand/control stage for eight_bit_alu. It accepts a byte stream over a valid/ready handshake: opcode byte, then operand A, then operand B. It drives the combinational ALU from registers and captures result, carry/borrow and status flag. It holds the result under a valid/ready handshake until consumed, and keeps a carry register so multi-byte add/subtract can be chained.

Parameters:
DATA_WIDTH, 8, operand/result width (matches `DATA_WIDTH)
CONTROL_WIDTH, 4, ALU function code width (matches `CONTROL_WIDTH)

Ports:
clk_i  input  1  clock, rising edge
rst_n_i  input  1  reset, asynchronous assert, active-low
data_i  input  DATA_WIDTH  byte stream: opcode, A, B
valid_i  input  1  data_i valid
ready_o  output  1  sequencer can accept data_i
abort_i  input  1  synchronous abort of current transaction
alu_a_o  output  DATA_WIDTH  to ALU a8_i
alu_b_o  output  DATA_WIDTH  to ALU b8_i
alu_f_o  output  CONTROL_WIDTH  to ALU f8_i
alu_carry_o  output  1  to ALU carry_borrow_i
alu_y_i  input  DATA_WIDTH  from ALU y8_o
alu_carry_i  input  1  from ALU carry_borrow_o
alu_flag_i  input  2  from ALU status_flag_o
result_o  output  DATA_WIDTH  captured result
carry_o  output  1  captured carry/borrow (also chain register)
flag_o  output  2  captured status flag
result_valid_o  output  1  result fields valid
result_ready_i  input  1  consumer accepts result

Behaviour:
- Reset (rst_n_i low, async): state IDLE; A, B, F registers 0; carry register 0; result_o 0; flag_o `DEFAULT_FLAG; result_valid_o 0; ready_o 1 once reset is released.
- Transfer occurs on a rising edge with valid_i && ready_o. Idle gaps are allowed between bytes.
- Opcode byte layout: bits[CONTROL_WIDTH-1:0] give the function, latched to F. Bit DATA_WIDTH-1 is the chain bit (C). The other bits are ignored.
- FSM:
  - IDLE: ready_o=1. On transfer, latch F and C, go to LOAD_A.
  - LOAD_A: ready_o=1. On transfer, latch A, go to LOAD_B.
  - LOAD_B: ready_o=1. On transfer, latch B, go to EXEC.
  - EXEC: ready_o=0, one cycle. Capture alu_y_i to result_o and alu_flag_i to flag_o. Capture alu_carry_i to carry_o and the carry register. Set result_valid_o, go to HOLD.
  - HOLD: ready_o=0, result_valid_o=1, all result fields stable. On result_ready_i, clear result_valid_o and go to IDLE.
- ALU drive:
  - alu_a_o, alu_b_o and alu_f_o come straight from the A, B and F registers (no combinational path from data_i).
  - alu_carry_o = C ? carry register : 0.
- Latency: the B-byte transfer is at edge N. EXEC is the cycle after edge N. result_valid_o is high after edge N+1. Minimum transaction is 5 cycles, opcode to result_ready.
- Carry register: written only in EXEC and cleared only by reset. It is never cleared by abort or by a non-chained op except through the EXEC capture (non-ADD/SUB functions produce 0).
- abort_i (synchronous, highest priority): from any state, next state is IDLE and result_valid_o goes to 0. Any byte presented in the same cycle is dropped. Carry register, result_o and flag_o keep their values.
- abort_i in EXEC: the capture is suppressed entirely; the carry register is not updated.
- result_ready_i outside HOLD is ignored. valid_i while ready_o=0 is ignored (no transfer).
- Chaining (multi-byte add): low byte is sent with C=0, then high bytes with C=1. Each byte's carry-in is the previous EXEC's carry-out.
- No arithmetic is done in this block. All widths are fixed by the parameters, with no wrap or sign handling beyond what the ALU does.

Decomposition:
- Shared defines file holds `DATA_WIDTH, `CONTROL_WIDTH, the function codes (`OUTPUT_A_PLUS_B, `OUTPUT_A_MINUS_B, ...) and the flag codes (`DEFAULT_FLAG, `ZERO_FLAG, `OVERFLOW_FLAG, `NEGATIVE_FLAG).
- Add to the same file: state encodings SEQ_IDLE, SEQ_LOAD_A, SEQ_LOAD_B, SEQ_EXEC, SEQ_HOLD, and the CHAIN_BIT index.
- No sub-module. The FSM, operand registers and result registers sit in one module.
- The testbench instantiates alu_op_sequencer together with eight_bit_alu.

Test Plan:
- Reset mid-HOLD: rst_n_i low -> result_valid_o=0, result_o=0x00, flag_o=`DEFAULT_FLAG, carry_o=0, ready_o=1 after release.
- Opcode `OUTPUT_A_PLUS_B (C=0), A=0xF0, B=0x20, result_ready_i held 1 -> result_o=0x10, carry_o=1, flag_o=`OVERFLOW_FLAG, result_valid_o high exactly one cycle, ready_o=1 the following cycle.
- Chained add: first op 0xFF+0x01 (C=0) -> result_o=0x00, carry_o=1. Second op 0x00+0x00 with C=1 -> alu_carry_o=1 during EXEC, result_o=0x01, carry_o=0, flag_o=`DEFAULT_FLAG.
- `OUTPUT_A_MINUS_B, A=0x05, B=0x05, then A=0x03, B=0x07 -> first gives 0x00 with `ZERO_FLAG, carry_o=0; second gives 0xFC, carry_o=1, `NEGATIVE_FLAG.
- Backpressure: result_ready_i=0 for 10 cycles while valid_i toggles -> result_o and flag_o stable, ready_o=0, no bytes accepted. One cycle of result_ready_i=1 -> back to IDLE.
- Abort: abort_i asserted in LOAD_B together with valid_i -> byte dropped, state IDLE, no result_valid_o. Abort in EXEC -> carry_o unchanged from its prior value.

Source files
------------

// File: rtl/alu_op_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer_pkg : shared widths, ALU function/flag codes, FSM states
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

`ifndef ALU_OP_SEQ_DEFINES
`define ALU_OP_SEQ_DEFINES
`define DATA_WIDTH        8
`define CONTROL_WIDTH     4

`define OUTPUT_A          4'h0
`define OUTPUT_B          4'h1
`define OUTPUT_A_PLUS_B   4'h2
`define OUTPUT_A_MINUS_B  4'h3
`define OUTPUT_A_AND_B    4'h4
`define OUTPUT_A_OR_B     4'h5
`define OUTPUT_A_XOR_B    4'h6
`define OUTPUT_NOT_A      4'h7

`define DEFAULT_FLAG      2'b00
`define ZERO_FLAG         2'b01
`define OVERFLOW_FLAG     2'b10
`define NEGATIVE_FLAG     2'b11
`endif

package alu_op_sequencer_pkg;

  localparam int CHAIN_BIT = `DATA_WIDTH - 1;

  typedef enum logic [2:0] {
    SEQ_IDLE   = 3'd0,
    SEQ_LOAD_A = 3'd1,
    SEQ_LOAD_B = 3'd2,
    SEQ_EXEC   = 3'd3,
    SEQ_HOLD   = 3'd4
  } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/eight_bit_alu.sv
// ---------------------------------------------------------------------------
// eight_bit_alu : combinational ALU with carry/borrow chaining and status flag
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module eight_bit_alu (
  input  logic [`DATA_WIDTH-1:0]    a8_i,
  input  logic [`DATA_WIDTH-1:0]    b8_i,
  input  logic [`CONTROL_WIDTH-1:0] f8_i,
  input  logic                      carry_borrow_i,
  output logic [`DATA_WIDTH-1:0]    y8_o,
  output logic                      carry_borrow_o,
  output logic [1:0]                status_flag_o
);

  localparam int DW = `DATA_WIDTH;

  logic [DW:0] w_sum;
  logic [DW:0] w_diff;

  // The extra MSB of the extended result is the carry-out / borrow-out.
  assign w_sum  = {1'b0, a8_i} + {1'b0, b8_i} + {{DW{1'b0}}, carry_borrow_i};
  assign w_diff = {1'b0, a8_i} - {1'b0, b8_i} - {{DW{1'b0}}, carry_borrow_i};

  always_comb begin
    y8_o           = '0;
    carry_borrow_o = 1'b0;
    status_flag_o  = `DEFAULT_FLAG;
    case (f8_i)
      `OUTPUT_A:         y8_o = a8_i;
      `OUTPUT_B:         y8_o = b8_i;
      `OUTPUT_A_PLUS_B:  {carry_borrow_o, y8_o} = w_sum;
      `OUTPUT_A_MINUS_B: {carry_borrow_o, y8_o} = w_diff;
      `OUTPUT_A_AND_B:   y8_o = a8_i & b8_i;
      `OUTPUT_A_OR_B:    y8_o = a8_i | b8_i;
      `OUTPUT_A_XOR_B:   y8_o = a8_i ^ b8_i;
      `OUTPUT_NOT_A:     y8_o = ~a8_i;
      default:           y8_o = '0;
    endcase

    // Carry-out reports overflow on add, borrow reports negative on subtract.
    if ((f8_i == `OUTPUT_A_PLUS_B) && carry_borrow_o) begin
      status_flag_o = `OVERFLOW_FLAG;
    end else if ((f8_i == `OUTPUT_A_MINUS_B) && carry_borrow_o) begin
      status_flag_o = `NEGATIVE_FLAG;
    end else if (y8_o == '0) begin
      status_flag_o = `ZERO_FLAG;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer : opcode/A/B byte loader and result holder for eight_bit_alu
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH    = `DATA_WIDTH,
  parameter int CONTROL_WIDTH = `CONTROL_WIDTH
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [DATA_WIDTH-1:0]    data_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic                     abort_i,
  output logic [DATA_WIDTH-1:0]    alu_a_o,
  output logic [DATA_WIDTH-1:0]    alu_b_o,
  output logic [CONTROL_WIDTH-1:0] alu_f_o,
  output logic                     alu_carry_o,
  input  logic [DATA_WIDTH-1:0]    alu_y_i,
  input  logic                     alu_carry_i,
  input  logic [1:0]               alu_flag_i,
  output logic [DATA_WIDTH-1:0]    result_o,
  output logic                     carry_o,
  output logic [1:0]               flag_o,
  output logic                     result_valid_o,
  input  logic                     result_ready_i
);

  seq_state_e               state_q, state_d;
  logic [DATA_WIDTH-1:0]    a_q, a_d;
  logic [DATA_WIDTH-1:0]    b_q, b_d;
  logic [CONTROL_WIDTH-1:0] f_q, f_d;
  logic                     chain_q, chain_d;
  logic                     carry_q, carry_d;
  logic [DATA_WIDTH-1:0]    result_q, result_d;
  logic [1:0]               flag_q, flag_d;
  logic                     valid_q, valid_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= SEQ_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      f_q      <= '0;
      chain_q  <= 1'b0;
      carry_q  <= 1'b0;
      result_q <= '0;
      flag_q   <= `DEFAULT_FLAG;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      f_q      <= f_d;
      chain_q  <= chain_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      flag_q   <= flag_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    f_d      = f_q;
    chain_d  = chain_q;
    carry_d  = carry_q;
    result_d = result_q;
    flag_d   = flag_q;
    valid_d  = valid_q;
    ready_o  = 1'b0;

    case (state_q)
      SEQ_IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          f_d     = data_i[CONTROL_WIDTH-1:0];
          chain_d = data_i[DATA_WIDTH-1];
          state_d = SEQ_LOAD_A;
        end
      end
      SEQ_LOAD_A: begin
        ready_o = 1'b1;
        if (valid_i) begin
          a_d     = data_i;
          state_d = SEQ_LOAD_B;
        end
      end
      SEQ_LOAD_B: begin
        ready_o = 1'b1;
        if (valid_i) begin
          b_d     = data_i;
          state_d = SEQ_EXEC;
        end
      end
      SEQ_EXEC: begin
        result_d = alu_y_i;
        flag_d   = alu_flag_i;
        carry_d  = alu_carry_i;
        valid_d  = 1'b1;
        state_d  = SEQ_HOLD;
      end
      SEQ_HOLD: begin
        if (result_ready_i) begin
          valid_d = 1'b0;
          state_d = SEQ_IDLE;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase

    // Abort wins over everything: drop any byte or capture from this cycle.
    if (abort_i) begin
      state_d  = SEQ_IDLE;
      a_d      = a_q;
      b_d      = b_q;
      f_d      = f_q;
      chain_d  = chain_q;
      carry_d  = carry_q;
      result_d = result_q;
      flag_d   = flag_q;
      valid_d  = 1'b0;
    end
  end

  assign alu_a_o        = a_q;
  assign alu_b_o        = b_q;
  assign alu_f_o        = f_q;
  assign alu_carry_o    = chain_q & carry_q;
  assign result_o       = result_q;
  assign carry_o        = carry_q;
  assign flag_o         = flag_q;
  assign result_valid_o = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_op_sequencer : sequencer + eight_bit_alu, directed vectors and corners
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_op_sequencer;

  localparam logic [1:0] F_DEF = 2'b00;
  localparam logic [1:0] F_ZERO = 2'b01;
  localparam logic [1:0] F_OVF = 2'b10;
  localparam logic [1:0] F_NEG = 2'b11;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o;
  logic       abort_i;
  logic [7:0] alu_a_o, alu_b_o;
  logic [3:0] alu_f_o;
  logic       alu_carry_o;
  logic [7:0] alu_y_i;
  logic       alu_carry_i;
  logic [1:0] alu_flag_i;
  logic [7:0] result_o;
  logic       carry_o;
  logic [1:0] flag_o;
  logic       result_valid_o;
  logic       result_ready_i;

  int total = 0;
  int passed = 0;

  alu_op_sequencer #(.DATA_WIDTH(8), .CONTROL_WIDTH(4)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready_o), .abort_i(abort_i), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .alu_f_o(alu_f_o), .alu_carry_o(alu_carry_o), .alu_y_i(alu_y_i),
    .alu_carry_i(alu_carry_i), .alu_flag_i(alu_flag_i), .result_o(result_o),
    .carry_o(carry_o), .flag_o(flag_o), .result_valid_o(result_valid_o),
    .result_ready_i(result_ready_i)
  );

  eight_bit_alu u_alu (
    .a8_i(alu_a_o), .b8_i(alu_b_o), .f8_i(alu_f_o), .carry_borrow_i(alu_carry_o),
    .y8_o(alu_y_i), .carry_borrow_o(alu_carry_i), .status_flag_o(alu_flag_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] res;
    logic       c;
    logic [1:0] flag;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    data_i  = d;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
  endtask

  // Leaves the bench one step after the B-byte edge, i.e. in the EXEC cycle.
  task automatic send3(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    send_byte(op);
    send_byte(a);
    send_byte(b);
  endtask

  task automatic run_txn(input string name, input logic [7:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] res, input logic c,
                         input logic [1:0] flag);
    send3(op, a, b);
    tick();
    chk({name, " valid"}, {15'd0, result_valid_o}, 16'd1);
    chk({name, " result"}, {8'd0, result_o}, {8'd0, res});
    chk({name, " carry"}, {15'd0, carry_o}, {15'd0, c});
    chk({name, " flag"}, {14'd0, flag_o}, {14'd0, flag});
    tick();
    chk({name, " ready after"}, {15'd0, ready_o}, 16'd1);
  endtask

  initial begin
    vecs[0] = '{8'h02, 8'hF0, 8'h20, 1'b0, 8'h10, 1'b1, F_OVF};
    vecs[1] = '{8'h02, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, F_OVF};
    vecs[2] = '{8'h82, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, F_DEF};
    vecs[3] = '{8'h03, 8'h05, 8'h05, 1'b0, 8'h00, 1'b0, F_ZERO};
    vecs[4] = '{8'h03, 8'h03, 8'h07, 1'b0, 8'hFC, 1'b1, F_NEG};
    vecs[5] = '{8'h83, 8'h10, 8'h00, 1'b1, 8'h0F, 1'b0, F_DEF};
    vecs[6] = '{8'h04, 8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0, F_DEF};
    vecs[7] = '{8'h82, 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, F_DEF};
    vecs[8] = '{8'h06, 8'hAA, 8'hAA, 1'b0, 8'h00, 1'b0, F_ZERO};
    vecs[9] = '{8'h72, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, F_DEF};

    rst_n_i = 1'b0;
    data_i = 8'h00;
    valid_i = 1'b0;
    abort_i = 1'b0;
    result_ready_i = 1'b1;

    #12;
    chk("reset valid", {15'd0, result_valid_o}, 16'd0);
    chk("reset result", {8'd0, result_o}, 16'd0);
    chk("reset flag", {14'd0, flag_o}, {14'd0, F_DEF});
    chk("reset carry", {15'd0, carry_o}, 16'd0);
    chk("reset alu_a", {8'd0, alu_a_o}, 16'd0);
    rst_n_i = 1'b1;
    tick();
    chk("ready after reset", {15'd0, ready_o}, 16'd1);

    // Back-to-back transactions with the result consumed immediately.
    for (int i = 0; i < 10; i++) begin
      send3(vecs[i].op, vecs[i].a, vecs[i].b);
      chk($sformatf("v%0d exec valid", i), {15'd0, result_valid_o}, 16'd0);
      chk($sformatf("v%0d exec ready", i), {15'd0, ready_o}, 16'd0);
      chk($sformatf("v%0d alu_a", i), {8'd0, alu_a_o}, {8'd0, vecs[i].a});
      chk($sformatf("v%0d alu_b", i), {8'd0, alu_b_o}, {8'd0, vecs[i].b});
      chk($sformatf("v%0d alu_f", i), {12'd0, alu_f_o}, {12'd0, vecs[i].op[3:0]});
      chk($sformatf("v%0d alu_carry", i), {15'd0, alu_carry_o}, {15'd0, vecs[i].cin});
      tick();
      chk($sformatf("v%0d valid", i), {15'd0, result_valid_o}, 16'd1);
      chk($sformatf("v%0d result", i), {8'd0, result_o}, {8'd0, vecs[i].res});
      chk($sformatf("v%0d carry", i), {15'd0, carry_o}, {15'd0, vecs[i].c});
      chk($sformatf("v%0d flag", i), {14'd0, flag_o}, {14'd0, vecs[i].flag});
      tick();
      chk($sformatf("v%0d valid drop", i), {15'd0, result_valid_o}, 16'd0);
      chk($sformatf("v%0d ready back", i), {15'd0, ready_o}, 16'd1);
    end

    // Backpressure: result held while valid_i toggles, nothing accepted.
    result_ready_i = 1'b0;
    send3(8'h02, 8'hF0, 8'h20);
    tick();
    for (int i = 0; i < 10; i++) begin
      valid_i = i[0];
      data_i = 8'h55;
      tick();
      chk($sformatf("bp%0d result", i), {8'd0, result_o}, 16'h0010);
      chk($sformatf("bp%0d flag", i), {14'd0, flag_o}, {14'd0, F_OVF});
      chk($sformatf("bp%0d ready", i), {15'd0, ready_o}, 16'd0);
      chk($sformatf("bp%0d valid", i), {15'd0, result_valid_o}, 16'd1);
    end
    valid_i = 1'b0;
    result_ready_i = 1'b1;
    tick();
    result_ready_i = 1'b0;
    chk("bp release valid", {15'd0, result_valid_o}, 16'd0);
    chk("bp release ready", {15'd0, ready_o}, 16'd1);
    result_ready_i = 1'b1;
    run_txn("post bp", 8'h02, 8'h01, 8'h02, 8'h03, 1'b0, F_DEF);

    // Abort in LOAD_B with a byte presented: byte dropped, back to IDLE.
    run_txn("set carry", 8'h02, 8'hFF, 8'h01, 8'h00, 1'b1, F_OVF);
    send_byte(8'h02);
    send_byte(8'h11);
    data_i = 8'h22;
    valid_i = 1'b1;
    abort_i = 1'b1;
    tick();
    valid_i = 1'b0;
    abort_i = 1'b0;
    chk("abortB ready", {15'd0, ready_o}, 16'd1);
    chk("abortB alu_b", {8'd0, alu_b_o}, 16'h0001);
    tick();
    tick();
    chk("abortB no valid", {15'd0, result_valid_o}, 16'd0);
    chk("abortB carry kept", {15'd0, carry_o}, 16'd1);
    send3(8'h04, 8'h0F, 8'h33);
    chk("abortB restart alu_a", {8'd0, alu_a_o}, 16'h000F);
    tick();
    chk("abortB restart result", {8'd0, result_o}, 16'h0003);
    tick();

    // Abort in EXEC: no capture, carry register untouched.
    run_txn("set carry2", 8'h02, 8'hFF, 8'h01, 8'h00, 1'b1, F_OVF);
    send3(8'h02, 8'h01, 8'h01);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abortE valid", {15'd0, result_valid_o}, 16'd0);
    chk("abortE ready", {15'd0, ready_o}, 16'd1);
    chk("abortE carry", {15'd0, carry_o}, 16'd1);
    chk("abortE result", {8'd0, result_o}, 16'h0000);
    chk("abortE flag", {14'd0, flag_o}, {14'd0, F_OVF});
    tick();
    chk("abortE still idle", {15'd0, result_valid_o}, 16'd0);

    // Asynchronous reset while holding a result.
    result_ready_i = 1'b0;
    send3(8'h02, 8'hF0, 8'h20);
    tick();
    chk("hold before reset", {15'd0, result_valid_o}, 16'd1);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("rst hold valid", {15'd0, result_valid_o}, 16'd0);
    chk("rst hold result", {8'd0, result_o}, 16'h0000);
    chk("rst hold flag", {14'd0, flag_o}, {14'd0, F_DEF});
    chk("rst hold carry", {15'd0, carry_o}, 16'd0);
    #3;
    rst_n_i = 1'b1;
    tick();
    chk("rst release ready", {15'd0, ready_o}, 16'd1);
    result_ready_i = 1'b1;
    run_txn("chain after rst", 8'h82, 8'h00, 8'h00, 8'h00, 1'b0, F_ZERO);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
